// File: rtl/pwm_timer_bank_pkg.sv
// Shared definitions for the four-channel PWM/timer bank.
// Holds the register map, the bitfield layouts and the prescaler helper.
// No logic or state lives here.
package pwm_timer_bank_pkg;

  // Channel count and internal widths
  localparam int NUM_CH = 4;
  localparam int PRE_W  = 7;
  localparam int CNT_W  = 8;

  // Config register indices
  localparam int CFG_CTRL   = 0;
  localparam int CFG_PERIOD = 1;
  localparam int CFG_DUTY0  = 2;
  localparam int CFG_IRQCTL = 6;
  localparam int CFG_CLEAR  = 7;

  // Status register indices
  localparam int ST_CNT   = 0;
  localparam int ST_FLAGS = 1;
  localparam int ST_WRAPS = 2;

  // Bit position of the level-sensitive counter clear in CLEAR
  localparam int CLEAR_BIT = 0;

  // CTRL layout: [7:5] prescale select, [4:1] channel enables, [0] run
  typedef struct packed {
    logic [2:0]        psc;
    logic [NUM_CH-1:0] ch_en;
    logic              run;
  } ctrl_t;

  // IRQCTL layout: [1] clear (rising edge), [0] enable
  typedef struct packed {
    logic [5:0] rsvd;
    logic       clr;
    logic       en;
  } irqctl_t;

  // Terminal prescaler value for a prescale select: 2^psc - 1
  function automatic logic [PRE_W-1:0] psc_limit(input logic [2:0] psc);
    logic [PRE_W-1:0] lim;
    lim = '0;
    for (int b = 0; b < PRE_W; b++) begin
      lim[b] = (b < int'(psc));
    end
    return lim;
  endfunction

endpackage

// File: rtl/pwm_timer_bank_channel.sv
// One PWM compare channel: duty shadow register, compare and output flop.
// Latency: cnt/duty shadow -> pwm_o is one registered cycle.
// No backpressure; the shadow loads only on load && ena, all state holds while ena is low.
module pwm_channel
  import pwm_timer_bank_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  output logic             pwm_o
);

  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic             pwm_q, pwm_d;

  // Next state: shadow follows duty when loading, output compares against the held shadow
  always_comb begin
    duty_sh_d = duty_sh_q;
    pwm_d     = pwm_q;
    if (ena) begin
      if (load) begin
        duty_sh_d = duty;
      end
      // Duty 0 never matches, duty above period always matches
      pwm_d = en && (cnt < duty_sh_q);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_timer_bank.sv
// Four-channel PWM/timer bank between the SPI register bank and the chip pins.
// Latency: cnt -> pwm_out 1 cycle, wrap -> irq_pending 1 cycle, irq_pending -> irq 1 cycle.
// No backpressure; ena low freezes every flop. Optional IRQ logic: define PWM_TIMER_BANK_IRQ_EN.
module pwm_timer_bank
  import pwm_timer_bank_pkg::*;
#(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic [NUM_CH-1:0]               pwm_out,
  output logic                            irq
);

  // Decoded configuration
  ctrl_t            ctrl;
  logic [CNT_W-1:0] period_cfg;
  logic [CNT_W-1:0] duty_cfg [NUM_CH];
  logic [CNT_W-1:0] clear_reg;
  logic [CNT_W-1:0] irqctl_reg;
  logic             clear;
  logic             unused_cfg;

  // Counter datapath state
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] wraps_q, wraps_d;

  logic              tick;
  logic              wrap;
  logic              shadow_load;
  logic [NUM_CH-1:0] pwm_vec;
  logic              irq_flag;

  // Slice the flat config bus into named fields
  always_comb begin
    ctrl       = ctrl_t'(config_regs[CFG_CTRL*REG_WIDTH +: CNT_W]);
    period_cfg = config_regs[CFG_PERIOD*REG_WIDTH +: CNT_W];
    for (int c = 0; c < NUM_CH; c++) begin
      duty_cfg[c] = config_regs[(CFG_DUTY0+c)*REG_WIDTH +: CNT_W];
    end
    clear_reg  = config_regs[CFG_CLEAR*REG_WIDTH +: CNT_W];
    irqctl_reg = config_regs[CFG_IRQCTL*REG_WIDTH +: CNT_W];
    clear      = clear_reg[CLEAR_BIT];
  end

  // Reserved config bits (and IRQCTL when the IRQ logic is left out) have no function
  assign unused_cfg = ^{clear_reg, irqctl_reg};

  // Prescaler, counter, period shadow and wrap count next state
  always_comb begin
    tick        = (pre_cnt_q == psc_limit(ctrl.psc));
    wrap        = ena && ctrl.run && !clear && tick && (cnt_q == period_sh_q);
    // Shadows track config while stopped or cleared, otherwise only at a wrap
    shadow_load = wrap || !ctrl.run || clear;

    pre_cnt_d   = pre_cnt_q;
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    wraps_d     = wraps_q;

    if (ena) begin
      if (clear) begin
        pre_cnt_d = '0;
        cnt_d     = '0;
      end else if (ctrl.run) begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        if (tick) begin
          // Period 0 lands here every tick: cnt stays 0 and each tick is a wrap
          cnt_d = (cnt_q == period_sh_q) ? '0 : cnt_q + 1'b1;
        end
      end
      if (shadow_load) begin
        period_sh_d = period_cfg;
      end
    end

    if (wrap) begin
      wraps_d = wraps_q + 1'b1;
    end
  end

  // Counter datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q   <= '0;
      cnt_q       <= '0;
      period_sh_q <= '0;
      wraps_q     <= '0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      wraps_q     <= wraps_d;
    end
  end

  // Compare channels, each with its own duty shadow
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_channel u_ch (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .load  (shadow_load),
      .duty  (duty_cfg[c]),
      .cnt   (cnt_q),
      .en    (ctrl.ch_en[c]),
      .pwm_o (pwm_vec[c])
    );
  end

  assign pwm_out = pwm_vec;

`ifdef PWM_TIMER_BANK_IRQ_EN
  irqctl_t irqctl;
  logic    irq_pending_q, irq_pending_d;
  logic    clr_prev_q, clr_prev_d;
  logic    irq_q, irq_d;

  // Sticky pending flag; a wrap in the same cycle as a clear edge keeps it set
  always_comb begin
    irqctl        = irqctl_t'(irqctl_reg);
    irq_pending_d = irq_pending_q;
    clr_prev_d    = clr_prev_q;
    irq_d         = irq_q;
    if (ena) begin
      if (wrap) begin
        irq_pending_d = 1'b1;
      end else if (irqctl.clr && !clr_prev_q) begin
        irq_pending_d = 1'b0;
      end
      clr_prev_d = irqctl.clr;
      irq_d      = irq_pending_q && irqctl.en;
    end
  end

  // IRQ registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pending_q <= 1'b0;
      clr_prev_q    <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      irq_pending_q <= irq_pending_d;
      clr_prev_q    <= clr_prev_d;
      irq_q         <= irq_d;
    end
  end

  assign irq      = irq_q;
  assign irq_flag = irq_pending_q;
`else
  assign irq      = 1'b0;
  assign irq_flag = 1'b0;
`endif

  // Status bus straight from registered state
  always_comb begin
    status_regs = '0;
    status_regs[ST_CNT*REG_WIDTH   +: CNT_W] = cnt_q;
    status_regs[ST_FLAGS*REG_WIDTH +: CNT_W] = {pwm_vec, 3'b000, irq_flag};
    status_regs[ST_WRAPS*REG_WIDTH +: CNT_W] = wraps_q;
  end

endmodule

// File: tb/tb_pwm_timer_bank.sv
// Bench for pwm_timer_bank: directed table, corner-case sequences and a randomized run
// checked against a behavioural model of the timer rules.
module tb_pwm_timer_bank;

`ifdef PWM_TIMER_BANK_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [7:0]  cfg [8];
  logic [63:0] config_regs;
  logic [63:0] status_regs;
  logic [3:0]  pwm_out;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  assign config_regs = {cfg[7], cfg[6], cfg[5], cfg[4], cfg[3], cfg[2], cfg[1], cfg[0]};

  pwm_timer_bank #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .config_regs (config_regs),
    .status_regs (status_regs),
    .pwm_out     (pwm_out),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_cnt, m_pre, m_per, m_wraps, m_pend, m_clrprev, m_irq;
  int m_duty [4];
  int m_pwm  [4];

  task automatic model_step();
    int psc, lim, run, clr, tick, wrap;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_per = 0; m_wraps = 0;
      m_pend = 0; m_clrprev = 0; m_irq = 0;
      for (int c = 0; c < 4; c++) begin m_duty[c] = 0; m_pwm[c] = 0; end
      return;
    end
    if (!ena) return;
    run  = int'(cfg[0][0]);
    clr  = int'(cfg[7][0]);
    psc  = int'(cfg[0][7:5]);
    lim  = (1 << psc) - 1;
    tick = (m_pre == lim) ? 1 : 0;
    wrap = (run != 0 && clr == 0 && tick != 0 && m_cnt == m_per) ? 1 : 0;
    for (int c = 0; c < 4; c++) m_pwm[c] = (cfg[0][1+c] && m_cnt < m_duty[c]) ? 1 : 0;
    if (IRQ_BUILD) begin
      m_irq = (m_pend != 0 && cfg[6][0]) ? 1 : 0;
      if (wrap != 0) m_pend = 1;
      else if (cfg[6][1] && m_clrprev == 0) m_pend = 0;
      m_clrprev = int'(cfg[6][1]);
    end
    if (wrap != 0) m_wraps = (m_wraps + 1) % 256;
    if (clr != 0) begin
      m_cnt = 0; m_pre = 0;
    end else if (run != 0) begin
      if (tick != 0) m_cnt = (wrap != 0) ? 0 : (m_cnt + 1) % 256;
      m_pre = (tick != 0) ? 0 : (m_pre + 1) % 128;
    end
    if (run == 0 || clr != 0 || wrap != 0) begin
      m_per = int'(cfg[1]);
      for (int c = 0; c < 4; c++) m_duty[c] = int'(cfg[2+c]);
    end
  endtask

  function automatic logic [3:0] model_pwm();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = (m_pwm[c] != 0);
    return v;
  endfunction

  function automatic logic [63:0] model_status();
    logic [63:0] e;
    e = '0;
    e[7:0]   = 8'(m_cnt);
    e[15:12] = model_pwm();
    e[8]     = (m_pend != 0);
    e[23:16] = 8'(m_wraps);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: DUT edge, model step, compare everything against the model
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check("model_status", status_regs, model_status());
    check("model_pwm", 64'(pwm_out), 64'(model_pwm()));
    check("model_irq", 64'(irq), 64'(m_irq));
  endtask

  task automatic count_high(input int n, output int h0, output int h1, output int h2);
    h0 = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      h2 += int'(pwm_out[2]);
    end
  endtask

  task automatic wait_wraps(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (status_regs[23:16] == 8'(target)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL wait_wraps: timed out, got %0d, expected %0d", status_regs[23:16], target);
    end
  endtask

  task automatic wait_cnt(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (status_regs[7:0] == 8'(target)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL wait_cnt: timed out, got %0d, expected %0d", status_regs[7:0], target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] period;
    logic [7:0] duty0;
    logic       clr;
    logic       en;
    int         ncyc;
    logic [7:0] exp_cnt;
    logic [7:0] exp_wraps;
    logic [3:0] exp_pwm;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int h0, h1, h2;

    //              ctrl   per  duty clr ena  n   cnt wraps pwm
    tbl[0] = '{8'h00, 8'd0, 8'd0, 1'b0, 1'b1,  3, 8'd0, 8'd0, 4'h0};
    tbl[1] = '{8'h02, 8'd9, 8'd3, 1'b0, 1'b1,  2, 8'd0, 8'd0, 4'h1};
    tbl[2] = '{8'h03, 8'd9, 8'd3, 1'b0, 1'b1, 10, 8'd0, 8'd1, 4'h0};
    tbl[3] = '{8'h03, 8'd9, 8'd3, 1'b0, 1'b1, 13, 8'd3, 8'd2, 4'h1};
    tbl[4] = '{8'h03, 8'd9, 8'd3, 1'b0, 1'b0,  5, 8'd3, 8'd2, 4'h1};
    tbl[5] = '{8'h03, 8'd9, 8'd3, 1'b0, 1'b1,  1, 8'd4, 8'd2, 4'h0};
    tbl[6] = '{8'h43, 8'd3, 8'd3, 1'b1, 1'b1,  3, 8'd0, 8'd2, 4'h1};
    tbl[7] = '{8'h43, 8'd3, 8'd3, 1'b0, 1'b1, 16, 8'd0, 8'd3, 4'h0};
    tbl[8] = '{8'h43, 8'd3, 8'd3, 1'b0, 1'b1,  5, 8'd1, 8'd3, 4'h1};
    tbl[9] = '{8'h43, 8'd3, 8'd3, 1'b0, 1'b1, 11, 8'd0, 8'd4, 4'h0};

    ena = 1'b1;
    for (int k = 0; k < 8; k++) cfg[k] = 8'h00;

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    check("reset_status", status_regs, 64'h0);
    check("reset_pwm", 64'(pwm_out), 64'h0);
    check("reset_irq", 64'(irq), 64'h0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      cfg[0] = tbl[i].ctrl;
      cfg[1] = tbl[i].period;
      cfg[2] = tbl[i].duty0;
      cfg[7] = {7'd0, tbl[i].clr};
      ena    = tbl[i].en;
      repeat (tbl[i].ncyc) cycle();
      check($sformatf("tbl%0d_cnt", i), 64'(status_regs[7:0]), 64'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_wraps", i), 64'(status_regs[23:16]), 64'(tbl[i].exp_wraps));
      check($sformatf("tbl%0d_pwm", i), 64'(pwm_out), 64'(tbl[i].exp_pwm));
    end

    // Duty shadowing, duty 0 and duty above period
    do_reset();
    cfg[0] = 8'h0E; cfg[1] = 8'd9; cfg[2] = 8'd3; cfg[3] = 8'd0; cfg[4] = 8'd200;
    cfg[7] = 8'h00;
    cycle(); cycle();
    cfg[0] = 8'h0F;
    count_high(10, h0, h1, h2);
    check("high_ch0_duty3", 64'(h0), 64'd3);
    check("high_ch1_duty0", 64'(h1), 64'd0);
    check("high_ch2_duty200", 64'(h2), 64'd10);
    count_high(5, h0, h1, h2);
    cfg[2] = 8'd7;
    count_high(5, h1, h2, h2);
    check("high_ch0_before_wrap", 64'(h0 + h1), 64'd3);
    count_high(10, h0, h1, h2);
    check("high_ch0_after_wrap", 64'(h0), 64'd7);

    // Reset mid-period
    cycle(); cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    check("midreset_status", status_regs, 64'h0);
    check("midreset_pwm", 64'(pwm_out), 64'h0);
    rst = 1'b0;

    // Wrap interrupt sequence
    do_reset();
    cfg[0] = 8'h02; cfg[1] = 8'd9; cfg[2] = 8'd3; cfg[3] = 8'd0; cfg[4] = 8'd0;
    cfg[6] = 8'h01;
    cycle(); cycle();
    cfg[0] = 8'h03;
    wait_wraps(1, 30);
    check("irq_pending_after_wrap", 64'(status_regs[8]), 64'(IRQ_BUILD));
    check("irq_one_cycle_after_wrap", 64'(irq), 64'd0);
    cycle();
    check("irq_two_cycles_after_wrap", 64'(irq), 64'(IRQ_BUILD));
    cfg[6] = 8'h03;
    cycle();
    check("irq_pending_cleared", 64'(status_regs[8]), 64'd0);
    cycle();
    check("irq_dropped", 64'(irq), 64'd0);
    wait_wraps(2, 30);
    check("irq_clear_held_no_reclear", 64'(status_regs[8]), 64'(IRQ_BUILD));
    cfg[6] = 8'h01; cycle();
    cfg[6] = 8'h03; cycle();
    check("irq_pending_cleared_again", 64'(status_regs[8]), 64'd0);
    cfg[6] = 8'h01; cycle();
    wait_cnt(9, 30);
    cfg[6] = 8'h03;
    cycle();
    check("irq_set_wins_wraps", 64'(status_regs[23:16]), 64'd3);
    check("irq_set_wins_pending", 64'(status_regs[8]), 64'(IRQ_BUILD));

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0)
        cfg[0] = {3'($urandom_range(0, 2)), 4'($urandom), 1'($urandom_range(0, 5) != 0)};
      if ($urandom_range(0, 29) == 0) cfg[1] = 8'($urandom_range(0, 12));
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 24) == 0)
          cfg[2+c] = ($urandom_range(0, 5) == 0) ? 8'd200 : 8'($urandom_range(0, 14));
      if ($urandom_range(0, 9) == 0) cfg[6] = 8'($urandom);
      if ($urandom_range(0, 39) == 0) cfg[7] = {7'($urandom), ~cfg[7][0]};
      ena = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_timer_bank.md
# pwm_timer_bank

Four-channel PWM/timer bank that consumes the flat `config_regs` bus produced by the SPI register wrapper and returns a flat `status_regs` bus to it.
- A prescaled up-counter with a programmable period drives four compare channels.
- Period and duty values are double-buffered so that updates are glitch-free.
- A sticky wrap interrupt is provided.
- The block sits directly downstream of the register bank, between the SPI-visible registers and the chip outputs.

## Interface
- `NUM_CFG`, 8, number of config registers; must be 8.
- `NUM_STATUS`, 8, number of status registers; must equal `NUM_CFG`.
- `REG_WIDTH`, 8, register width in bits; must be 8.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ena`  in  1  global enable; when low, all state freezes.
- `config_regs`  in  `NUM_CFG*REG_WIDTH`  flat config bus; register k occupies bits [8k+7:8k].
- `status_regs`  out  `NUM_STATUS*REG_WIDTH`  flat status bus, same packing.
- `pwm_out`  out  4  registered PWM outputs.
- `irq`  out  1  registered wrap interrupt.

## Operation
- Config map:
  - 0 CTRL: [0] run, [4:1] channel enable ch0..ch3, [7:5] prescale select PSC.
  - 1 PERIOD.
  - 2..5 DUTY ch0..ch3.
  - 6 IRQCTL: [0] irq enable, [1] irq clear, acting on the 0→1 edge only.
  - 7 CLEAR: [0] counter clear, level-sensitive; [7:1] ignored.
- Status map:
  - 0: counter value `cnt`.
  - 1: {`pwm_out`[3:0], 3'b000, `irq_pending`}.
  - 2: wrap count, 8-bit, rolls over 255→0.
  - 3..7: 0.
- Prescaler: 7-bit `pre_cnt`. `tick` is asserted when `pre_cnt` == 2^PSC−1, at which point `pre_cnt` returns to 0; otherwise `pre_cnt` increments. PSC=0 gives a tick every cycle; PSC=7 gives one tick per 128 cycles.
- Counter advances only when `ena` && run && !clear && `tick`:
  - if `cnt` == `period_sh`: `cnt`←0, `wrap` asserts for one cycle, wrap count increments.
  - otherwise `cnt`←`cnt`+1.
- Clear held high (with `ena`): `cnt`=0, `pre_cnt`=0, no wraps occur.
- Shadows (`period_sh`, `duty_sh`[0..3]):
  - load from config on every `wrap`;
  - load continuously while run=0 or clear=1;
  - hold at all other times.
- Channel output: `pwm_out`[c] ← en[c] && (`cnt` < `duty_sh`[c]), registered.
  - Duty 0 → constantly low.
  - Duty > `period_sh` → constantly high.
- Period 0: `cnt` stays at 0 and every tick is a wrap.
- `irq_pending`:
  - set on `wrap`;
  - cleared on a rising edge of IRQCTL[1], detected against a registered copy of that bit;
  - if set and clear coincide, set wins.
- `irq` = `irq_pending` && IRQCTL[0], registered.
- `ena` low: counter, prescaler, shadows, pending flag, edge register and outputs all hold their values.

## Timing
- Reset: `cnt`, `pre_cnt`, shadows, wrap count, `irq_pending`, edge register, `pwm_out`, `irq` and all of `status_regs` are 0.
- Latency:
  - config write → shadow: next wrap, or 1 cycle while run=0/clear=1;
  - `cnt` change → `pwm_out`: 1 cycle;
  - `wrap` → `irq_pending`: 1 cycle;
  - `irq_pending` → `irq`: 1 cycle.
- `status_regs` is driven combinationally from registered state; no additional latency.
- Reset asserted mid-period returns all state to the reset values on the next edge. Shadows reload from config while run=0.

## Configuration
- `PWM_TIMER_BANK_IRQ_EN` defined: IRQCTL decoding, `irq_pending`, the clear edge detector and `irq` are implemented as specified.
- Not defined:
  - `irq` is tied to 0;
  - status 1 bit 0 reads 0;
  - IRQCTL is ignored;
  - no IRQ flops are implemented.
- The wrap count is present in both builds.

## Structure
- Package `pwm_timer_bank_pkg`:
  - config/status index localparams (`CFG_CTRL`…`CFG_CLEAR`, `ST_CNT`, `ST_FLAGS`, `ST_WRAPS`);
  - CTRL/IRQCTL bit positions;
  - `NUM_CH`=4;
  - the prescaler width.
- Sub-module `pwm_channel`:
  - holds the duty shadow register, compare logic and output flop;
  - inputs: `load`, `duty`, `cnt`, `en`;
  - instantiated `NUM_CH` times.
- Prescaler, counter and IRQ logic live in the top module.

## Test plan
- Reset → `pwm_out`=0, `irq`=0, `status_regs`=0; with run=0 the counter holds at 0.
- PSC=0, PERIOD=9, DUTY0=3, en0, run → `cnt` cycles 0..9; `pwm_out`[0] is high for 3 of every 10 cycles; wrap count +1 per 10 cycles.
- PSC=2, PERIOD=3 → `cnt` increments every 4 clocks; wrap every 16 clocks.
- DUTY0 changed 3→7 mid-period → `pwm_out`[0] high time is unchanged until the next wrap, then 7 cycles; DUTY1=0 → ch1 always low; DUTY2=200 with PERIOD=9 → ch2 always high.
- IRQ build, irq enable=1 → `irq` rises 2 cycles after the wrap. IRQCTL[1] 0→1 clears it; holding the bit at 1 does not re-clear later wraps. A clear in the same cycle as a wrap leaves `irq_pending`=1.
- `ena`=0 for 5 cycles mid-run → `cnt`/`pwm_out` freeze, then resume from the same values. CLEAR=1 → `cnt`=0 next cycle and held while CLEAR stays 1.
